// File: rtl/axi_lite_apb_bridge.sv
// axi_lite_apb_bridge
//
// AXI4-Lite slave to APB4 master bridge. Each single-beat AXI-Lite read or
// write becomes exactly one APB SETUP/ACCESS transfer, and the APB
// completion comes back as a B or R response. Only one APB transfer is in
// flight at a time. AW, W and AR each own a one-entry holding register, so
// address and data may arrive in any order and may be accepted while a
// previous response is still waiting.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   awaddr/awprot/awvalid/awready   AXI write address channel
//   wdata/wstrb/wvalid/wready       AXI write data channel
//   bresp/bvalid/bready             AXI write response channel
//   araddr/arprot/arvalid/arready   AXI read address channel
//   rdata/rresp/rvalid/rready       AXI read data channel
//   paddr/pprot/psel/penable/pwrite/pwdata/pstrb   APB request
//   prdata/pready/pslverr           APB completion
//   fsm_state                       current FSM state (debug observation)
//
// Handshake rule (all AXI channels): a channel transfers on a rising edge
// where its valid and ready are both high. awready/wready/arready are pure
// registered flags and never depend on the matching valid, so the master
// must hold valid and payload until that edge. bvalid/rvalid, once raised,
// stay high with stable payload until the edge where bready/rready is high.

module axi_lite_apb_bridge #(
    parameter int  ADDR_WIDTH     = 32,
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,

    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,

    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,

    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,

    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [2:0]            pprot,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,

    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WRESP  = 3'd3,
        RRESP  = 3'd4
    } state_t;

    // A zero timeout disables the abort path; the counter keeps one bit so
    // the declarations stay legal.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t state_q;
    state_t state_d;

    // Holding registers
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]            aw_prot;
    logic                  aw_full;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_full;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]            ar_prot;
    logic                  ar_full;

    // Held low through reset and for the first edge after release so that
    // every ready output reads 0 while rst_n is asserted.
    logic                  ready_en;

    logic                  last_grant_write;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  write_ok;
    logic                  read_ok;
    logic                  grant_write;
    logic                  grant_read;
    logic                  xfer_done;
    logic                  xfer_abort;
    logic                  xfer_end;
    logic                  timeout_hit;
    logic [1:0]            end_resp;

    assign write_ok    = aw_full & w_full;
    assign read_ok     = ar_full;
    assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);
    assign xfer_end    = xfer_done | xfer_abort;
    assign end_resp    = (xfer_abort || pslverr) ? 2'b10 : 2'b00;

    assign awready   = ready_en & ~aw_full;
    assign wready    = ready_en & ~w_full;
    assign arready   = ready_en & ~ar_full;
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign bvalid    = (state_q == WRESP);
    assign rvalid    = (state_q == RRESP);
    assign fsm_state = state_q;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_write = 1'b0;
        grant_read  = 1'b0;
        xfer_done   = 1'b0;
        xfer_abort  = 1'b0;
        case (state_q)
            IDLE: begin
                // On a conflict the side that did not win last time goes first.
                if (write_ok && (!read_ok || !last_grant_write)) begin
                    grant_write = 1'b1;
                    state_d     = SETUP;
                end else if (read_ok) begin
                    grant_read = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    xfer_done = 1'b1;
                end else if (timeout_hit) begin
                    xfer_abort = 1'b1;
                end
                if (pready || timeout_hit) begin
                    state_d = pwrite ? WRESP : RRESP;
                end
            end
            WRESP: begin
                if (bready) begin
                    state_d = IDLE;
                end
            end
            RRESP: begin
                if (rready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding registers. A slot can only be refilled once it is empty, so
    // a fill and a clear never land on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            aw_addr  <= '0;
            aw_prot  <= '0;
            aw_full  <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            w_full   <= 1'b0;
            ar_addr  <= '0;
            ar_prot  <= '0;
            ar_full  <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            if (awvalid && awready) begin
                aw_addr <= awaddr;
                aw_prot <= awprot;
                aw_full <= 1'b1;
            end else if (xfer_end && pwrite) begin
                aw_full <= 1'b0;
            end

            if (wvalid && wready) begin
                w_data <= wdata;
                w_strb <= wstrb;
                w_full <= 1'b1;
            end else if (xfer_end && pwrite) begin
                w_full <= 1'b0;
            end

            if (arvalid && arready) begin
                ar_addr <= araddr;
                ar_prot <= arprot;
                ar_full <= 1'b1;
            end else if (xfer_end && !pwrite) begin
                ar_full <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // APB request registers and captured responses. The request fields are
    // loaded only at grant, so they stay stable through SETUP and ACCESS.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddr            <= '0;
            pprot            <= '0;
            pwrite           <= 1'b0;
            pwdata           <= '0;
            pstrb            <= '0;
            last_grant_write <= 1'b0;
            bresp            <= 2'b00;
            rresp            <= 2'b00;
            rdata            <= '0;
        end else begin
            if (grant_write) begin
                paddr            <= aw_addr;
                pprot            <= aw_prot;
                pwrite           <= 1'b1;
                pwdata           <= w_data;
                pstrb            <= w_strb;
                last_grant_write <= 1'b1;
            end else if (grant_read) begin
                paddr            <= ar_addr;
                pprot            <= ar_prot;
                pwrite           <= 1'b0;
                pwdata           <= '0;
                pstrb            <= '0;
                last_grant_write <= 1'b0;
            end

            if (xfer_end) begin
                if (pwrite) begin
                    bresp <= end_resp;
                end else begin
                    rresp <= end_resp;
                    rdata <= xfer_abort ? '0 : prdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // ACCESS wait counter: zeroed during SETUP, so it starts from 0 on the
    // first ACCESS cycle and counts cycles spent without pready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_q == SETUP) begin
            wait_cnt <= '0;
        end else if (state_q == ACCESS && !pready && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// tb_axi_lite_apb_bridge
//
// Drives the bridge from an AXI-Lite master sequence and answers on APB
// with a small slave whose wait states and error flag are set per transfer.
// Expected transfers, response codes, read data and cycle timing come from
// a transaction-level model: each accepted request produces one APB record,
// the response appears a fixed number of edges after the last request
// handshake, and a conflict is resolved by alternating the last winner.

module tb_axi_lite_apb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;
    localparam int RW = 1 + 3 + SW + AW + DW;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [2:0]    fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scoreboard of APB transfers the model expects, oldest first.
    logic [RW-1:0] exp_q[$];

    // APB slave behaviour for the current transfer(s).
    int            cfg_wait = 0;
    bit            cfg_err  = 1'b0;
    logic [DW-1:0] rd_salt  = '0;

    // Model state: which side won the most recent grant (reset: read).
    bit model_last_wr = 1'b0;

    axi_lite_apb_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .awaddr   (awaddr),
        .awprot   (awprot),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arprot   (arprot),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .paddr    (paddr),
        .pprot    (pprot),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] rd_func(input logic [AW-1:0] a);
        return a ^ rd_salt;
    endfunction

    function automatic logic [RW-1:0] pack(input bit wr, input logic [2:0] prot,
                                           input logic [SW-1:0] strb,
                                           input logic [AW-1:0] addr,
                                           input logic [DW-1:0] data);
        return {wr, prot, strb, addr, data};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- APB slave ----------------
    initial begin : apb_slave
        int            acc_n;
        logic [RW-1:0] setup_rec;
        logic [RW-1:0] cur;
        logic [RW-1:0] want;
        acc_n     = 0;
        setup_rec = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        forever begin
            @(posedge clk);
            #1;
            cur     = pack(pwrite, pprot, pstrb, paddr, pwdata);
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            if (psel && !penable) begin
                setup_rec = cur;
                acc_n     = 0;
            end else if (psel && penable) begin
                chk("apb_hold", cur, setup_rec);
                if (acc_n == cfg_wait) begin
                    pready  = 1'b1;
                    pslverr = cfg_err;
                    prdata  = rd_func(paddr);
                    chk("apb_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        chk("apb_xfer", cur, want);
                    end
                end
                acc_n++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One transfer from an idle bridge. a_dly/w_dly: cycles before the
    // address/data valid rises; wt: slave wait cycles; r_dly: cycles the
    // response is held before bready/rready.
    task automatic run_xfer(input bit wr, input logic [AW-1:0] addr, input logic [2:0] prot,
                            input logic [DW-1:0] data, input logic [SW-1:0] strb,
                            input int a_dly, input int w_dly, input int wt,
                            input bit err, input int r_dly);
        bit            a_done, w_done, a_hs, w_hs, timed_out, r_hs;
        int            t_last, done_e, n;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_rdata;
        cfg_wait = wt;
        cfg_err  = err;
        a_done   = 1'b0;
        w_done   = !wr;
        t_last   = cyc;
        for (int c = 0; c < 40 && !(a_done && w_done); c++) begin
            if (c == a_dly) begin
                if (wr) begin
                    awaddr = addr; awprot = prot; awvalid = 1'b1;
                end else begin
                    araddr = addr; arprot = prot; arvalid = 1'b1;
                end
            end
            if (wr && c == w_dly) begin
                wdata = data; wstrb = strb; wvalid = 1'b1;
            end
            a_hs = wr ? (awvalid && awready) : (arvalid && arready);
            w_hs = wvalid && wready;
            @(posedge clk);
            #1;
            if (a_hs) begin
                a_done = 1'b1; t_last = cyc;
                awvalid = 1'b0; arvalid = 1'b0; awaddr = $urandom; araddr = $urandom;
            end
            if (w_hs) begin
                w_done = 1'b1; t_last = cyc;
                wvalid = 1'b0; wdata = $urandom;
            end
        end
        chk("req_handshake", a_done && w_done, 1);

        timed_out = (wt >= TO);
        done_e    = t_last + 2 + (timed_out ? TO : wt + 1);
        exp_resp  = (timed_out || err) ? 2'b10 : 2'b00;
        exp_rdata = timed_out ? '0 : rd_func(addr);
        if (!timed_out) begin
            exp_q.push_back(wr ? pack(1'b1, prot, strb, addr, data)
                               : pack(1'b0, prot, '0, addr, '0));
        end
        model_last_wr = wr;

        n    = 0;
        r_hs = 1'b0;
        for (int c = 0; c < 60 && !r_hs; c++) begin
            chk("psel", psel, (cyc >= t_last + 1) && (cyc < done_e));
            chk("penable", penable, (cyc >= t_last + 2) && (cyc < done_e));
            chk(wr ? "bvalid" : "rvalid", wr ? bvalid : rvalid, cyc >= done_e);
            chk(wr ? "awready" : "arready", wr ? awready : arready, cyc >= done_e);
            if (wr) chk("wready", wready, cyc >= done_e);
            if (cyc >= done_e) begin
                if (wr) begin
                    chk("bresp", bresp, exp_resp);
                end else begin
                    chk("rresp", rresp, exp_resp);
                    chk("rdata", rdata, exp_rdata);
                end
                if (n == r_dly) begin
                    bready = 1'b1; rready = 1'b1; r_hs = 1'b1;
                end
                n++;
            end
            @(posedge clk);
            #1;
            bready = 1'b0;
            rready = 1'b0;
        end
        chk("rsp_handshake", r_hs, 1);
        chk("valid_drop", wr ? bvalid : rvalid, 0);
    endtask

    // AW, W and AR presented in the same cycle to an idle bridge.
    task automatic run_conflict(input int wt);
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        logic [2:0]    wp, rp;
        bit            wr_first, err;
        int            t0, d1, d2, b_at, r_at;
        wa = $urandom; ra = $urandom; wd = $urandom;
        ws = 4'($urandom_range(0, 15));
        wp = 3'($urandom_range(0, 7));
        rp = 3'($urandom_range(0, 7));
        err = 1'($urandom_range(0, 1));
        cfg_wait = wt;
        cfg_err  = err;
        bready = 1'b1;
        rready = 1'b1;
        awaddr = wa; awprot = wp; awvalid = 1'b1;
        wdata  = wd; wstrb  = ws; wvalid  = 1'b1;
        araddr = ra; arprot = rp; arvalid = 1'b1;
        chk("conf_ready", {awready, wready, arready}, 3'b111);
        @(posedge clk);
        #1;
        t0 = cyc;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wr_first = !model_last_wr;
        if (wr_first) begin
            exp_q.push_back(pack(1'b1, wp, ws, wa, wd));
            exp_q.push_back(pack(1'b0, rp, '0, ra, '0));
        end else begin
            exp_q.push_back(pack(1'b0, rp, '0, ra, '0));
            exp_q.push_back(pack(1'b1, wp, ws, wa, wd));
        end
        model_last_wr = !wr_first;
        d1 = t0 + 3 + wt;
        d2 = t0 + 7 + 2 * wt;
        b_at = -1;
        r_at = -1;
        for (int c = 0; c < 40 && (b_at < 0 || r_at < 0); c++) begin
            if (bvalid && b_at < 0) begin
                b_at = cyc;
                chk("conf_bresp", bresp, err ? 2'b10 : 2'b00);
            end
            if (rvalid && r_at < 0) begin
                r_at = cyc;
                chk("conf_rresp", rresp, err ? 2'b10 : 2'b00);
                chk("conf_rdata", rdata, rd_func(ra));
            end
            @(posedge clk);
            #1;
        end
        chk("conf_b_time", b_at, wr_first ? d1 : d2);
        chk("conf_r_time", r_at, wr_first ? d2 : d1);
        bready = 1'b0;
        rready = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main_seq
        int e;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_apb", {paddr, pprot, psel, penable, pwrite, pstrb}, 0);
        chk("reset_pwdata", pwdata, 0);
        chk("reset_axi", {awready, wready, arready, bvalid, bresp, rvalid, rresp}, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_state", fsm_state, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {awready, wready, arready}, 3'b111);

        // Zero-wait write, AW and W together
        run_xfer(1'b1, 32'h0000_1004, 3'b000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0, 0);
        // W four cycles before AW, three wait states
        run_xfer(1'b1, 32'h0000_0020, 3'b001, 32'h1234_5678, 4'hF, 4, 0, 3, 1'b0, 0);
        // Read with slave error, response held 5 cycles
        rd_salt = 32'hA5A5_A5A5 ^ 32'h0000_0040;
        run_xfer(1'b0, 32'h0000_0040, 3'b010, '0, '0, 0, 0, 0, 1'b1, 5);

        // Arbitration: first conflict after reset goes to the write,
        // a lone write in between flips the next conflict to read-first.
        run_conflict(0);
        run_conflict(1);
        run_xfer(1'b1, 32'h0000_0100, 3'b000, 32'h0BAD_F00D, 4'h3, 0, 1, 0, 1'b0, 0);
        run_conflict(2);

        // Timeout on a read, then a normal transfer
        run_xfer(1'b0, 32'h0000_0044, 3'b010, '0, '0, 0, 0, 10, 1'b0, 1);
        run_xfer(1'b0, 32'h0000_0048, 3'b000, '0, '0, 1, 0, 1, 1'b0, 0);
        run_xfer(1'b1, 32'h0000_004C, 3'b011, 32'hCAFE_0001, 4'h8, 0, 2, 20, 1'b0, 0);

        // AR accepted while the write response is held; the read's APB
        // transfer waits for the bridge to return to IDLE.
        cfg_wait = 0;
        cfg_err  = 1'b0;
        awaddr = 32'h80; awprot = 3'b000; awvalid = 1'b1;
        wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        exp_q.push_back(pack(1'b1, 3'b000, 4'hF, 32'h80, 32'h5555_AAAA));
        repeat (3) @(posedge clk);
        #1;
        chk("hold_bvalid", bvalid, 1);
        chk("hold_arready", arready, 1);
        araddr = 32'h84; arprot = 3'b101; arvalid = 1'b1;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        exp_q.push_back(pack(1'b0, 3'b101, '0, 32'h84, '0));
        model_last_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_no_psel", psel, 0);
            chk("hold_ar_full", arready, 0);
            chk("hold_bvalid_on", bvalid, 1);
            @(posedge clk);
            #1;
        end
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
        e = cyc;
        chk("hold_bvalid_off", bvalid, 0);
        chk("hold_psel_idle", psel, 0);
        @(posedge clk);
        #1;
        chk("hold_psel_setup", {psel, penable}, 2'b10);
        @(posedge clk);
        #1;
        chk("hold_penable", {psel, penable}, 2'b11);
        @(posedge clk);
        #1;
        chk("hold_rvalid_time", cyc - e, 3);
        chk("hold_rvalid", rvalid, 1);
        chk("hold_rdata", rdata, rd_func(32'h84));
        chk("hold_rresp", rresp, 2'b00);
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;

        // Random transfers with occasional conflicts
        for (int i = 0; i < 40; i++) begin
            bit            wr, err;
            logic [2:0]    prot;
            logic [SW-1:0] strb;
            int            a_dly, w_dly, wt, r_dly;
            wr    = 1'($urandom_range(0, 1));
            err   = 1'($urandom_range(0, 1));
            prot  = 3'($urandom_range(0, 7));
            strb  = 4'($urandom_range(0, 15));
            a_dly = int'($urandom_range(0, 3));
            w_dly = int'($urandom_range(0, 3));
            wt    = int'($urandom_range(0, 5));
            r_dly = int'($urandom_range(0, 3));
            rd_salt = $urandom;
            run_xfer(wr, $urandom, prot, $urandom, strb, a_dly, w_dly, wt, err, r_dly);
            if (i % 8 == 7) run_conflict(int'($urandom_range(0, 2)));
        end

        // Asynchronous reset in the middle of a write ACCESS phase
        cfg_wait = 100;
        cfg_err  = 1'b0;
        awaddr = 32'hC0; awprot = 3'b000; awvalid = 1'b1;
        wdata = 32'h7777_8888; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int c = 0; c < 10 && !penable; c++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_pre_penable", penable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_apb", {psel, penable}, 2'b00);
        chk("rst_axi", {awready, wready, arready, bvalid, rvalid}, 0);
        chk("rst_state", fsm_state, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_last_wr = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_ready", {awready, wready, arready}, 3'b111);
            chk("post_rst_quiet", {bvalid, rvalid, psel}, 3'b000);
        end

        // Arbitration history was reset too: write wins the next conflict
        run_conflict(0);
        run_xfer(1'b1, 32'h0000_0200, 3'b000, 32'h0102_0304, 4'h1, 0, 0, 0, 1'b0, 0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
